// File: rtl/v_issue_tracker.sv
// v_issue_tracker: scoreboard for a vector pipeline. Tracks per-register
// write/read reservations and per-unit reservations with down-counters and
// issues a held instruction combinationally once every operand and the
// target unit are free.
// Optional feature: define V_CHAIN_EN to let a source read a register that
// is still being written, in the single cycle its first element is ready
// (chain slot).
module v_issue_tracker #(
    parameter int NUM_VREG = 8,
    parameter int NUM_VFU  = 8,
    parameter int MAX_VL   = 64,
    parameter int DLY_W    = 4,
    localparam int VR_W = $clog2(NUM_VREG),
    localparam int FU_W = $clog2(NUM_VFU),
    localparam int VL_W = $clog2(MAX_VL) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req_vld,
    input  logic [VR_W-1:0]     i_vi,
    input  logic [VR_W-1:0]     i_vj,
    input  logic [VR_W-1:0]     i_vk,
    input  logic                i_vi_en,
    input  logic                i_vj_en,
    input  logic                i_vk_en,
    input  logic [FU_W-1:0]     i_fu,
    input  logic [DLY_W-1:0]    i_fu_delay,
    input  logic [VL_W-1:0]     i_vl,
    output logic                o_issue,
    output logic [NUM_VREG-1:0] o_vreg_busy,
    output logic [NUM_VREG-1:0] o_vreg_rd_busy,
    output logic [NUM_VREG-1:0] o_vreg_chain_n,
    output logic [NUM_VFU-1:0]  o_vfu_busy
);

    // Write counter must hold the largest delay plus the largest length.
    localparam int WC_W = $clog2((2 ** DLY_W) - 1 + MAX_VL + 1);

    localparam logic [WC_W-1:0] WC_ZERO = {WC_W{1'b0}};
    localparam logic [WC_W-1:0] WC_ONE  = {{(WC_W-1){1'b0}}, 1'b1};
    localparam logic [VL_W-1:0] VL_ZERO = {VL_W{1'b0}};
    localparam logic [VL_W-1:0] VL_ONE  = {{(VL_W-1){1'b0}}, 1'b1};
    localparam logic [VL_W-1:0] VL_MAX  = VL_W'(MAX_VL);

    logic [WC_W-1:0]     wcnt_q [NUM_VREG];
    logic [WC_W-1:0]     wcnt_d [NUM_VREG];
    logic [VL_W-1:0]     rcnt_q [NUM_VREG];
    logic [VL_W-1:0]     rcnt_d [NUM_VREG];
    logic [VL_W-1:0]     fcnt_q [NUM_VFU];
    logic [VL_W-1:0]     fcnt_d [NUM_VFU];

    logic [NUM_VREG-1:0] vreg_busy_q, vreg_busy_d;
    logic [NUM_VREG-1:0] vreg_rd_busy_q, vreg_rd_busy_d;
    logic [NUM_VFU-1:0]  vfu_busy_q, vfu_busy_d;

    logic [VL_W-1:0]     eff_len_s;
    logic [WC_W-1:0]     wload_s;
    logic [NUM_VREG-1:0] chain_hit_s;
    logic [NUM_VREG-1:0] wr_sel_s;
    logic [NUM_VREG-1:0] rd_sel_s;
    logic [NUM_VFU-1:0]  fu_sel_s;
    logic                dst_rdy_s;
    logic                vj_rdy_s;
    logic                vk_rdy_s;
    logic                fu_rdy_s;
    logic                issue_s;

    // Effective vector length (0 encodes MAX_VL) and the write reservation.
    always_comb begin
        eff_len_s = (i_vl == VL_ZERO) ? VL_MAX : i_vl;
        wload_s   = WC_W'(i_fu_delay) + WC_W'(eff_len_s);
    end

    // Hazard checks against pre-issue state; issue is suppressed in reset.
    always_comb begin
        dst_rdy_s = (!i_vi_en) ||
                    ((wcnt_q[i_vi] == WC_ZERO) && (rcnt_q[i_vi] == VL_ZERO));
        vj_rdy_s  = (!i_vj_en) || (wcnt_q[i_vj] == WC_ZERO) || chain_hit_s[i_vj];
        vk_rdy_s  = (!i_vk_en) || (wcnt_q[i_vk] == WC_ZERO) || chain_hit_s[i_vk];
        fu_rdy_s  = (fcnt_q[i_fu] == VL_ZERO);
        issue_s   = rst_n && i_req_vld && dst_rdy_s && vj_rdy_s && vk_rdy_s && fu_rdy_s;
    end

    assign o_issue = issue_s;

    // Decode which counters the accepted instruction loads.
    always_comb begin
        wr_sel_s = {NUM_VREG{1'b0}};
        rd_sel_s = {NUM_VREG{1'b0}};
        fu_sel_s = {NUM_VFU{1'b0}};
        for (int n = 0; n < NUM_VREG; n++) begin
            wr_sel_s[n] = issue_s && i_vi_en && (i_vi == VR_W'(n));
            rd_sel_s[n] = issue_s && ((i_vj_en && (i_vj == VR_W'(n))) ||
                                      (i_vk_en && (i_vk == VR_W'(n))));
        end
        for (int u = 0; u < NUM_VFU; u++) begin
            fu_sel_s[u] = issue_s && (i_fu == FU_W'(u));
        end
    end

    // Counter next state: load on issue overrides the saturating decrement.
    always_comb begin
        vreg_busy_d    = {NUM_VREG{1'b0}};
        vreg_rd_busy_d = {NUM_VREG{1'b0}};
        vfu_busy_d     = {NUM_VFU{1'b0}};
        for (int n = 0; n < NUM_VREG; n++) begin
            wcnt_d[n] = WC_ZERO;
            rcnt_d[n] = VL_ZERO;
            if (wr_sel_s[n]) begin
                wcnt_d[n] = wload_s;
            end else if (wcnt_q[n] != WC_ZERO) begin
                wcnt_d[n] = wcnt_q[n] - WC_ONE;
            end else begin
                wcnt_d[n] = WC_ZERO;
            end
            if (rd_sel_s[n]) begin
                rcnt_d[n] = eff_len_s;
            end else if (rcnt_q[n] != VL_ZERO) begin
                rcnt_d[n] = rcnt_q[n] - VL_ONE;
            end else begin
                rcnt_d[n] = VL_ZERO;
            end
            vreg_busy_d[n]    = (wcnt_d[n] != WC_ZERO);
            vreg_rd_busy_d[n] = (rcnt_d[n] != VL_ZERO);
        end
        for (int u = 0; u < NUM_VFU; u++) begin
            fcnt_d[u] = VL_ZERO;
            if (fu_sel_s[u]) begin
                fcnt_d[u] = eff_len_s;
            end else if (fcnt_q[u] != VL_ZERO) begin
                fcnt_d[u] = fcnt_q[u] - VL_ONE;
            end else begin
                fcnt_d[u] = VL_ZERO;
            end
            vfu_busy_d[u] = (fcnt_d[u] != VL_ZERO);
        end
    end

    // Reservation counters and their registered busy decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_VREG; n++) begin
                wcnt_q[n] <= WC_ZERO;
                rcnt_q[n] <= VL_ZERO;
            end
            for (int u = 0; u < NUM_VFU; u++) begin
                fcnt_q[u] <= VL_ZERO;
            end
            vreg_busy_q    <= {NUM_VREG{1'b0}};
            vreg_rd_busy_q <= {NUM_VREG{1'b0}};
            vfu_busy_q     <= {NUM_VFU{1'b0}};
        end else begin
            wcnt_q         <= wcnt_d;
            rcnt_q         <= rcnt_d;
            fcnt_q         <= fcnt_d;
            vreg_busy_q    <= vreg_busy_d;
            vreg_rd_busy_q <= vreg_rd_busy_d;
            vfu_busy_q     <= vfu_busy_d;
        end
    end

    assign o_vreg_busy    = vreg_busy_q;
    assign o_vreg_rd_busy = vreg_rd_busy_q;
    assign o_vfu_busy     = vfu_busy_q;

`ifdef V_CHAIN_EN
    logic [VL_W-1:0]     len_q [NUM_VREG];
    logic [VL_W-1:0]     len_d [NUM_VREG];
    logic [NUM_VREG-1:0] chain_n_q, chain_n_d;

    // Chain slot: write counter has counted the delay down to the length.
    always_comb begin
        chain_hit_s = {NUM_VREG{1'b0}};
        chain_n_d   = {NUM_VREG{1'b1}};
        for (int n = 0; n < NUM_VREG; n++) begin
            chain_hit_s[n] = (wcnt_q[n] != WC_ZERO) && (wcnt_q[n] == WC_W'(len_q[n]));
            len_d[n]       = wr_sel_s[n] ? eff_len_s : len_q[n];
            chain_n_d[n]   = !((wcnt_d[n] != WC_ZERO) && (wcnt_d[n] == WC_W'(len_d[n])));
        end
    end

    // Latched lengths and the registered active-low chain slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_VREG; n++) begin
                len_q[n] <= VL_ZERO;
            end
            chain_n_q <= {NUM_VREG{1'b1}};
        end else begin
            len_q     <= len_d;
            chain_n_q <= chain_n_d;
        end
    end

    assign o_vreg_chain_n = chain_n_q;
`else
    assign chain_hit_s    = {NUM_VREG{1'b0}};
    assign o_vreg_chain_n = {NUM_VREG{1'b1}};
`endif

endmodule

// File: doc/v_issue_tracker.md
V_ISSUE_TRACKER -- requirements
Module: v_issue_tracker

Interface
REQ-001 Parameter NUM_VREG, default 8: number of V registers tracked.
REQ-002 Parameter NUM_VFU, default 8: number of vector functional units tracked.
REQ-003 Parameter MAX_VL, default 64: maximum vector length; VL_W = clog2(MAX_VL)+1.
REQ-004 Parameter DLY_W, default 4: width of the functional-unit delay field.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 i_req_vld  in  1  decoded vector instruction present; held stable until o_issue.
REQ-008 i_vi, i_vj, i_vk  in  clog2(NUM_VREG) each  destination, first source and second source register indices.
REQ-009 i_vi_en, i_vj_en, i_vk_en  in  1 each  operand-use enables.
REQ-010 i_fu  in  clog2(NUM_VFU)  target functional unit index.
REQ-011 i_fu_delay  in  DLY_W  functional-unit pipeline delay in cycles.
REQ-012 i_vl  in  VL_W  vector length; 0 is interpreted as MAX_VL.
REQ-013 o_issue  out  1  instruction accepted this cycle.
REQ-014 o_vreg_busy  out  NUM_VREG  per-register write reservation active.
REQ-015 o_vreg_rd_busy  out  NUM_VREG  per-register read reservation active.
REQ-016 o_vreg_chain_n  out  NUM_VREG  active-low chain slot per register.
REQ-017 o_vfu_busy  out  NUM_VFU  per-unit reservation active.

Function
REQ-018 Per register: write counter wcnt and read counter rcnt; per unit: fcnt; each counter decrements by 1 per cycle while nonzero and saturates at 0.
REQ-019 Busy outputs SHALL be registered decodes: o_vreg_busy[n] = (wcnt[n]!=0), o_vreg_rd_busy[n] = (rcnt[n]!=0), o_vfu_busy[u] = (fcnt[u]!=0).
REQ-020 Effective length L = (i_vl==0) ? MAX_VL : i_vl.
REQ-021 Destination ready when !i_vi_en, or both wcnt[i_vi] and rcnt[i_vi] are 0 (RAW/WAW/WAR protection).
REQ-022 Source ready (j, k independently) when the enable is low, or wcnt of that register is 0, or that register is in its chain slot (REQ-026).
REQ-023 Unit ready when fcnt[i_fu]==0.
REQ-024 o_issue SHALL be combinational: i_req_vld AND all ready terms; zero-latency, no internal queue; requester holds the request until o_issue.
REQ-025 On issue (same edge): wcnt[i_vi] <= i_fu_delay + L if i_vi_en; rcnt[i_vj]/rcnt[i_vk] <= L if enabled; fcnt[i_fu] <= L; the load overrides the decrement.
REQ-026 Chain slot: o_vreg_chain_n[n]=0 for exactly the one cycle in which wcnt[n]==L_n (L latched per register at issue); all other cycles 1.
REQ-027 i_vj==i_vk with both enabled: single rcnt load of L; i_vi==i_vj with both enabled: each check is made against pre-issue state, both counters load.
REQ-028 Each reservation of N cycles SHALL show busy for exactly the N cycles following the issue edge; a new request sees the freed resource in cycle N+1.
REQ-029 Loads whose sum exceeds the counter width are not permitted; wcnt width SHALL hold (2^DLY_W - 1) + MAX_VL.

Reset
REQ-030 rst_n low: all counters and latched lengths to 0 asynchronously; o_vreg_busy, o_vreg_rd_busy, o_vfu_busy = 0; o_vreg_chain_n = all 1; o_issue = 0 while rst_n low.
REQ-031 Reset mid-operation SHALL abandon all reservations; first edge after release behaves as after power-up.

Configuration
REQ-032 Macro V_CHAIN_EN defined: chain-slot term of REQ-022 active and REQ-026 drives o_vreg_chain_n.
REQ-033 V_CHAIN_EN undefined: sources require wcnt==0 only; o_vreg_chain_n tied to all 1; latched length registers omitted.

Verification
REQ-034 Reset, then request vi=1, vj=2, vk=3, fu=2, delay=3, vl=4 -> o_issue=1; busy[1] high 7 cycles, rd_busy[2],[3] and vfu_busy[2] high 4 cycles.
REQ-035 V_CHAIN_EN: after REQ-034, held request vj=1, vi=4, fu=3 -> o_issue in exactly the cycle chain_n[1]=0 (3 cycles after first issue); without the macro, 7 cycles after it.
REQ-036 Request writing vi=2 while rd_busy[2] -> o_issue=0 until rd_busy[2] clears, then 1.
REQ-037 vl=0, fu=5 -> vfu_busy[5] high exactly 64 cycles.
REQ-038 Assert rst_n low mid-reservation -> all busy outputs 0 immediately, chain_n all 1; a new request issues on the first cycle after release.
